// File: rtl/sdram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// sdram_arbiter : shares one SDRAM controller command port between p0 (video),
// p1 (CPU/UART) and periodic auto-refresh. Optional: SDRAM_ARB_ROUND_ROBIN_EN.
// Rev 1.0
//==============================================================================
module sdram_arbiter #(
  parameter int ADDR_W           = 21,
  parameter int REFRESH_INTERVAL = 1300
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [3:0]        p0_wmask,
  output logic              p0_ack,
  output logic [31:0]       p0_rdata,
  output logic              p0_rdata_en,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [3:0]        p1_wmask,
  output logic              p1_ack,
  output logic [31:0]       p1_rdata,
  output logic              p1_rdata_en,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_refresh,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_done,
  input  logic [31:0]       mem_rdata
);

  localparam int               CNT_W        = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] C_CNT_RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_P0   = 2'd1;
  localparam logic [1:0] OWN_P1   = 2'd2;
  localparam logic [1:0] OWN_REF  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ref_pend_q, ref_pend_d;

  logic              mem_valid_q, mem_valid_d;
  logic              mem_refresh_q, mem_refresh_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [31:0]       p0_rdata_q, p0_rdata_d;
  logic [31:0]       p1_rdata_q, p1_rdata_d;
  logic              p0_rdata_en_q, p0_rdata_en_d;
  logic              p1_rdata_en_q, p1_rdata_en_d;

  logic              w_sel_ref;
  logic              w_sel_p0;
  logic              w_sel_p1;
  logic              w_sel_any;
  logic              w_prefer_p1;
  logic              w_expire;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // Set when p0 was granted last, so p1 wins the next contended selection.
  logic rr_q, rr_d;
  assign w_prefer_p1 = rr_q;
`else
  assign w_prefer_p1 = 1'b0;
`endif

  assign w_expire  = (cnt_q == '0);
  assign w_sel_any = w_sel_ref | w_sel_p0 | w_sel_p1;

  // Arbitration: refresh first, then the requesters.
  always_comb begin
    w_sel_ref = 1'b0;
    w_sel_p0  = 1'b0;
    w_sel_p1  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (ref_pend_q) begin
        w_sel_ref = 1'b1;
      end else if (p0_req && p1_req) begin
        w_sel_p1 = w_prefer_p1;
        w_sel_p0 = ~w_prefer_p1;
      end else if (p0_req) begin
        w_sel_p0 = 1'b1;
      end else if (p1_req) begin
        w_sel_p1 = 1'b1;
      end
    end
  end

  // Next-state logic: transaction FSM, owner tracking and refresh timer.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = w_expire ? C_CNT_RELOAD : cnt_q - CNT_W'(1);
    // An expiry coinciding with a refresh selection leaves one refresh pending.
    ref_pend_d = w_expire | (ref_pend_q & ~w_sel_ref);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    rr_d       = rr_q;
    if (w_sel_p0) rr_d = 1'b1;
    if (w_sel_p1) rr_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_sel_any) begin
          state_d = ST_ISSUE;
          if (w_sel_ref)     owner_d = OWN_REF;
          else if (w_sel_p0) owner_d = OWN_P0;
          else               owner_d = OWN_P1;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_done) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Output logic: command fields, acks and read-data routing.
  always_comb begin
    mem_valid_d   = mem_valid_q;
    mem_refresh_d = mem_refresh_q;
    mem_wr_d      = mem_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wmask_d   = mem_wmask_q;
    p0_ack_d      = 1'b0;
    p1_ack_d      = 1'b0;
    p0_rdata_d    = p0_rdata_q;
    p1_rdata_d    = p1_rdata_q;
    p0_rdata_en_d = 1'b0;
    p1_rdata_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_sel_ref) begin
          mem_valid_d   = 1'b1;
          mem_refresh_d = 1'b1;
          mem_wr_d      = 1'b0;
          mem_addr_d    = '0;
          mem_wdata_d   = '0;
          mem_wmask_d   = '0;
        end else if (w_sel_p0) begin
          mem_valid_d   = 1'b1;
          mem_refresh_d = 1'b0;
          mem_wr_d      = p0_wr;
          mem_addr_d    = p0_addr;
          mem_wdata_d   = p0_wdata;
          mem_wmask_d   = p0_wmask;
          p0_ack_d      = 1'b1;
        end else if (w_sel_p1) begin
          mem_valid_d   = 1'b1;
          mem_refresh_d = 1'b0;
          mem_wr_d      = p1_wr;
          mem_addr_d    = p1_addr;
          mem_wdata_d   = p1_wdata;
          mem_wmask_d   = p1_wmask;
          p1_ack_d      = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) mem_valid_d = 1'b0;
      end
      ST_WAIT: begin
        if (mem_done && !mem_wr_q) begin
          if (owner_q == OWN_P0) begin
            p0_rdata_d    = mem_rdata;
            p0_rdata_en_d = 1'b1;
          end else if (owner_q == OWN_P1) begin
            p1_rdata_d    = mem_rdata;
            p1_rdata_en_d = 1'b1;
          end
        end
      end
      default: begin
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_NONE;
      cnt_q         <= C_CNT_RELOAD;
      ref_pend_q    <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_refresh_q <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wmask_q   <= '0;
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
      p0_rdata_en_q <= 1'b0;
      p1_rdata_en_q <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      rr_q          <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      ref_pend_q    <= ref_pend_d;
      mem_valid_q   <= mem_valid_d;
      mem_refresh_q <= mem_refresh_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wmask_q   <= mem_wmask_d;
      p0_ack_q      <= p0_ack_d;
      p1_ack_q      <= p1_ack_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
      p0_rdata_en_q <= p0_rdata_en_d;
      p1_rdata_en_q <= p1_rdata_en_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      rr_q          <= rr_d;
`endif
    end
  end

  assign mem_valid   = mem_valid_q;
  assign mem_refresh = mem_refresh_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;
  assign p0_ack      = p0_ack_q;
  assign p1_ack      = p1_ack_q;
  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;
  assign p0_rdata_en = p0_rdata_en_q;
  assign p1_rdata_en = p1_rdata_en_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// tb_sdram_arbiter : randomized requesters and controller model, scoreboard
// against a transaction-level arbitration/refresh/memory reference model.
//==============================================================================
module tb_sdram_arbiter;

  localparam int AW    = 21;
  localparam int RI    = 16;
  localparam int P0    = 0;
  localparam int P1    = 1;
  localparam int PREF  = 2;
  localparam int PNONE = 3;

  typedef struct packed {
    logic          refr;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wmask;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          req   [2];
  logic          wr    [2];
  logic [AW-1:0] addr  [2];
  logic [31:0]   wdata [2];
  logic [3:0]    wmask [2];

  logic          p0_ack, p1_ack, p0_rdata_en, p1_rdata_en;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          mem_valid, mem_ready, mem_refresh, mem_wr, mem_done;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_wmask;

  sdram_arbiter #(.ADDR_W(AW), .REFRESH_INTERVAL(RI)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(req[0]), .p0_wr(wr[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_wmask(wmask[0]),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rdata_en(p0_rdata_en),
    .p1_req(req[1]), .p1_wr(wr[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_wmask(wmask[1]),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rdata_en(p1_rdata_en),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_refresh(mem_refresh), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  int  checks, failures;
  int  rate [2];
  int  ready_pct;
  bit  quiet, hold_done;

  logic [31:0] rmem [logic [AW-1:0]];
  logic [31:0] cmem [logic [AW-1:0]];
  cmd_t        cmd_q [$];
  logic [31:0] rd_q0 [$];
  logic [31:0] rd_q1 [$];

  bit  m_busy, m_acc, m_pend, m_own_wr, m_rr;
  int  m_own, m_n;
  logic [31:0] last_rd [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return {11'h5A5, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ctl_read(input logic [AW-1:0] a);
    return cmem.exists(a) ? cmem[a] : init_word(a);
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    int s;
    s = $urandom_range(0, 5);
    if (s == 0) return 21'h012345;
    if (s == 1) return 21'h1FFFFF;
    if (s == 2) return '0;
    return AW'($urandom_range(0, 7));
  endfunction

  // Requesters: hold req until ack, then drop or present a fresh request.
  initial begin
    for (int g = 0; g < 2; g++) begin
      req[g] = 1'b0; wr[g] = 1'b0; addr[g] = '0; wdata[g] = '0; wmask[g] = '0;
    end
    forever begin
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) begin
        if (quiet) begin
          req[g] = 1'b0;
        end else if (req[g] && !(g == 0 ? p0_ack : p1_ack)) begin
          req[g] = 1'b1;
        end else if ($urandom_range(0, 99) < rate[g]) begin
          req[g]   = 1'b1;
          wr[g]    = 1'($urandom_range(0, 1));
          addr[g]  = pick_addr();
          wdata[g] = $urandom;
          wmask[g] = 4'($urandom_range(0, 15));
        end else begin
          req[g] = 1'b0;
        end
      end
    end
  end

  // Controller model: random ready, random completion latency, spurious done.
  initial begin
    bit            c_wait, c_wr, c_ref;
    logic [AW-1:0] c_addr;
    logic [31:0]   c_wdata;
    logic [3:0]    c_wmask;
    int            c_delay;
    c_wait = 0; c_wr = 0; c_ref = 0; c_addr = '0; c_wdata = '0; c_wmask = '0; c_delay = 0;
    mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset_n && mem_valid && mem_ready && !c_wait) begin
        c_wait = 1; c_wr = mem_wr; c_ref = mem_refresh; c_addr = mem_addr;
        c_wdata = mem_wdata; c_wmask = mem_wmask; c_delay = $urandom_range(0, 4);
      end
      @(posedge clk); #1;
      mem_done  = 1'b0;
      mem_ready = ($urandom_range(0, 99) < ready_pct);
      if (c_wait) begin
        if (!hold_done) begin
          if (c_delay == 0) begin
            mem_done = 1'b1;
            c_wait   = 0;
            if (!c_ref) begin
              if (c_wr) cmem[c_addr] = merge(ctl_read(c_addr), c_wdata, c_wmask);
              else      mem_rdata = ctl_read(c_addr);
            end
          end else begin
            c_delay--;
          end
        end
      end else if ($urandom_range(0, 99) < 4) begin
        mem_done  = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  // Reference model + monitor: evaluates each clock edge at the following negedge.
  initial begin
    bit            s_req [2], s_wr [2];
    logic [AW-1:0] s_addr [2];
    logic [31:0]   s_wdata [2];
    logic [3:0]    s_wmask [2];
    bit            s_ready, s_done, en0, en1;
    int            g;
    cmd_t          e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_busy = 0; m_acc = 0; m_pend = 0; m_n = 0; m_rr = 0; m_own = PNONE; m_own_wr = 0;
        cmd_q.delete(); rd_q0.delete(); rd_q1.delete();
        last_rd[0] = '0; last_rd[1] = '0;
      end else begin
        m_n++;
        g = PNONE;
        if (!m_busy) begin
          if (m_pend) g = PREF;
          else if (s_req[0] && s_req[1]) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            g = m_rr ? P1 : P0;
`else
            g = P0;
`endif
          end else if (s_req[0]) g = P0;
          else if (s_req[1]) g = P1;
        end
        en0 = 0; en1 = 0;
        if (m_busy && m_acc && s_done) begin
          m_busy = 0;
          if (m_own != PREF && !m_own_wr) begin
            if (m_own == P0) en0 = 1; else en1 = 1;
          end
        end else if (m_busy && !m_acc && s_ready) begin
          m_acc = 1;
          if (cmd_q.size() > 0) void'(cmd_q.pop_front());
        end
        if (g != PNONE) begin
          m_busy = 1; m_acc = 0; m_own = g;
          e = '0;
          if (g == PREF) begin
            m_pend = 0;
            e.refr = 1'b1;
          end else begin
            m_own_wr = s_wr[g];
            e.wr = s_wr[g]; e.addr = s_addr[g]; e.wdata = s_wdata[g]; e.wmask = s_wmask[g];
            if (s_wr[g]) rmem[s_addr[g]] = merge(ref_read(s_addr[g]), s_wdata[g], s_wmask[g]);
            else if (g == P0) rd_q0.push_back(ref_read(s_addr[g]));
            else rd_q1.push_back(ref_read(s_addr[g]));
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            m_rr = (g == P0);
`endif
          end
          cmd_q.push_back(e);
        end
        if (m_n % RI == 0) m_pend = 1;

        chk("p0_ack", 64'(p0_ack), 64'(g == P0));
        chk("p1_ack", 64'(p1_ack), 64'(g == P1));
        chk("mem_valid", 64'(mem_valid), 64'(m_busy && !m_acc));
        if (m_busy && !m_acc && cmd_q.size() > 0) begin
          e = cmd_q[0];
          chk("mem_refresh", 64'(mem_refresh), 64'(e.refr));
          if (!e.refr)
            chk("mem_cmd", 64'({mem_wr, mem_addr, mem_wdata, mem_wmask}),
                64'({e.wr, e.addr, e.wdata, e.wmask}));
        end
        chk("p0_rdata_en", 64'(p0_rdata_en), 64'(en0));
        chk("p1_rdata_en", 64'(p1_rdata_en), 64'(en1));
        if (en0 && rd_q0.size() > 0) last_rd[0] = rd_q0.pop_front();
        if (en1 && rd_q1.size() > 0) last_rd[1] = rd_q1.pop_front();
        chk("p0_rdata", 64'(p0_rdata), 64'(last_rd[0]));
        chk("p1_rdata", 64'(p1_rdata), 64'(last_rd[1]));
      end
      for (int k = 0; k < 2; k++) begin
        s_req[k] = req[k]; s_wr[k] = wr[k]; s_addr[k] = addr[k];
        s_wdata[k] = wdata[k]; s_wmask[k] = wmask[k];
      end
      s_ready = mem_ready; s_done = mem_done;
    end
  end

  task automatic phase(input int r0, input int r1, input int rdy, input int cycles);
    rate[0] = r0; rate[1] = r1; ready_pct = rdy; quiet = 0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int k;
    checks = 0; failures = 0;
    reset_n = 1'b0; quiet = 1; hold_done = 0; rate[0] = 0; rate[1] = 0; ready_pct = 100;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (40) @(negedge clk);

    phase(60, 60, 100, 300);
    phase(100, 100, 100, 300);
    phase(100, 40, 80, 300);
    phase(20, 80, 60, 300);
    phase(50, 50, 15, 300);
    phase(0, 100, 100, 200);

    // Reset while a transaction waits for completion.
    hold_done = 1; ready_pct = 100; rate[0] = 100; rate[1] = 100; quiet = 0;
    k = 0;
    while (!(m_busy && m_acc) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_wait", 64'(m_busy && m_acc), 64'd1);
    quiet = 1;
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    chk("rst_mem_out", 64'({mem_valid, mem_refresh, mem_wr, mem_addr, mem_wdata, mem_wmask}), 64'd0);
    chk("rst_port_flags", 64'({p0_ack, p0_rdata_en, p1_ack, p1_rdata_en}), 64'd0);
    chk("rst_p0_rdata", 64'(p0_rdata), 64'd0);
    chk("rst_p1_rdata", 64'(p1_rdata), 64'd0);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    hold_done = 0;
    repeat (30) @(negedge clk);

    phase(70, 70, 70, 300);

    quiet = 1; ready_pct = 100;
    repeat (60) @(negedge clk);
    chk("rd_q_drained", 64'(rd_q0.size() + rd_q1.size()), 64'd0);
    chk("cmd_q_drained", 64'(cmd_q.size()), 64'(m_busy ? 1 : 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares one SDRAM controller command port (MT48LC2M32B2, 2M x 32, 86.4 MHz system clock) between two requesters and an internal refresh scheduler.
- p0 is the video scan-out port and p1 the CPU/UART port.
- One transaction is outstanding at a time. Read data is routed back to the owning requester.

Parameters:
- ADDR_W, 21, word address width (bank 2 + row 11 + column 8).
- REFRESH_INTERVAL, 1300, clock cycles between refresh requests (< 1350 = 15.625 us at 86.4 MHz).

Ports:
- clk  in  1  system clock (86.4 MHz), all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- p0_req  in  1  request; level, held until p0_ack is seen.
- p0_wr  in  1  1 = write, 0 = read; valid while p0_req = 1.
- p0_addr  in  ADDR_W  word address.
- p0_wdata  in  32  write data.
- p0_wmask  in  4  byte enable, 1 = byte written.
- p0_ack  out  1  one-cycle pulse: request latched.
- p0_rdata  out  32  read data.
- p0_rdata_en  out  1  one-cycle pulse: p0_rdata valid.
- p1_req, p1_wr, p1_addr, p1_wdata, p1_wmask, p1_ack, p1_rdata, p1_rdata_en: same as p0.
- mem_valid  out  1  command valid toward controller.
- mem_ready  in  1  controller can accept a command.
- mem_refresh  out  1  1 = auto-refresh command (other fields don't-care).
- mem_wr  out  1  write flag.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  32  write data.
- mem_wmask  out  4  byte enable.
- mem_done  in  1  one-cycle pulse: command complete (read data valid for reads).
- mem_rdata  in  32  read data, valid with mem_done.

Behaviour:
- Reset: all outputs 0, state ST_IDLE, refresh counter = REFRESH_INTERVAL-1, refresh_pending = 0, owner = none.
- Refresh counter:
  - Decrements every cycle.
  - At 0 it reloads REFRESH_INTERVAL-1 and sets refresh_pending.
  - If refresh_pending is already 1 at expiry, it stays 1. No accumulation; at most one pending refresh.
  - refresh_pending clears on the cycle refresh is selected.
  - If selection and expiry happen in the same cycle, pending ends at 1.
- Priority at selection: refresh_pending > p0 > p1 (fixed).
- ST_IDLE: if any candidate is pending, select the winner at the clock edge.
  - Register mem_* fields and set mem_valid <= 1.
  - Winning requester's pN_ack <= 1 for exactly one cycle. No ack for refresh.
  - Record owner (0, 1 or refresh); go to ST_ISSUE.
  - pN_req is sampled only in ST_IDLE. A requester lowers req or presents a new request the cycle after ack.
- ST_ISSUE: mem_valid and fields are held stable until a cycle with mem_valid & mem_ready. mem_valid <= 0 on that edge; go to ST_WAIT.
- ST_WAIT: wait for mem_done.
  - On mem_done for a read by owner N: pN_rdata <= mem_rdata and pN_rdata_en <= 1 for one cycle, the cycle after mem_done.
  - Writes and refresh produce no rdata_en.
  - Return to ST_IDLE. The earliest next selection is the cycle after return.
- mem_done outside ST_WAIT is ignored.
- pN_rdata holds its last value between pulses.
- Minimum grant-to-grant spacing: 3 cycles (IDLE -> ISSUE -> WAIT -> IDLE) with mem_ready = 1 and immediate mem_done.
- Reset asserted mid-transaction: immediate return to reset values. The outstanding transaction is abandoned, and no ack or rdata_en is produced for it.

Optional Feature:
- SDRAM_ARB_ROUND_ROBIN_EN defined: p0 and p1 alternate priority.
  - The requester granted last has lower priority on the next contended selection.
  - Initial preference after reset is p0.
  - Refresh remains top priority and does not change the round-robin pointer.
- Undefined: fixed priority p0 > p1; p1 may starve under continuous p0 traffic.

Test Plan:
- Read by p1 alone, addr 21'h012345, mem_ready = 1, mem_done 4 cycles after acceptance with mem_rdata 32'hDEADBEEF -> p1_ack single pulse; mem_addr = 21'h012345, mem_wr = 0; p1_rdata = 32'hDEADBEEF with p1_rdata_en one cycle after mem_done; p0_rdata_en stays 0.
- p0 write (wdata 32'h11223344, wmask 4'b0101) and p1 read raised in the same cycle -> p0 granted first with mem_wmask = 4'b0101; p1 granted after p0's mem_done; without the macro, with p0_req re-raised continuously, p1 is never granted.
- SDRAM_ARB_ROUND_ROBIN_EN defined, both requests held continuously -> grants alternate p0, p1, p0, p1.
- REFRESH_INTERVAL = 16, no requests -> mem_valid with mem_refresh = 1 every 16 cycles. With p0_req pending at expiry, refresh is issued before p0.
- mem_ready held 0 for 10 cycles after selection -> mem_valid and mem_addr stay stable 10 cycles; acceptance on the first cycle mem_ready = 1; exactly one ack total.
- reset_n pulled low in ST_WAIT -> all outputs 0 immediately; a later mem_done produces no rdata_en.
